gslcd_v1_0_power_seq: RTL and testbench

//  Power/enable sequencer for the LCD panel and its timing generator.

---
 rtl/gslcd_v1_0_power_seq.sv | 138 +++++++++++++
 tb/tb_gslcd_v1_0_power_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gslcd_v1_0_power_seq.sv
// LCD panel power sequencer: panel rail -> timing EN -> DISP -> backlight on the way up,
// reverse order on the way down, with cycle and whole-frame dwell between steps.
//
// state    | meaning
// ---------+----------------------------------------------------
// OFF      | everything off, waiting for REQ_ON
// PWR_UP   | panel rail on, waiting C_PWR_DELAY_CYCLES
// FWAIT_UP | timing EN on, counting C_DISP_FRAMES frame starts
// DISP_UP  | DISP pin on, waiting C_BL_DELAY_CYCLES
// ON       | backlight on, waiting for REQ_ON to drop
// BL_DN    | backlight off, waiting C_BL_DELAY_CYCLES
// FWAIT_DN | DISP off, counting C_DISP_FRAMES frame starts
// PWR_DN   | timing EN off, waiting C_PWR_DELAY_CYCLES
module gslcd_v1_0_power_seq #(
  parameter int unsigned C_CNT_WIDTH        = 20,
  parameter int unsigned C_PWR_DELAY_CYCLES = 1000,
  parameter int unsigned C_DISP_FRAMES      = 2,
  parameter int unsigned C_BL_DELAY_CYCLES  = 500
) (
  input  logic PCLK,
  input  logic RESETN,
  input  logic REQ_ON,
  input  logic FORCE_OFF,
  input  logic FRAME_START,
  output logic PANEL_PWR,
  output logic TIMING_EN,
  output logic LCD_DISP,
  output logic BL_EN,
  output logic STATUS_ON,
  output logic BUSY
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_UP   = 3'd1,
    S_FWAIT_UP = 3'd2,
    S_DISP_UP  = 3'd3,
    S_ON       = 3'd4,
    S_BL_DN    = 3'd5,
    S_FWAIT_DN = 3'd6,
    S_PWR_DN   = 3'd7
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0] PWR_TC = C_CNT_WIDTH'(C_PWR_DELAY_CYCLES - 1);
  localparam logic [C_CNT_WIDTH-1:0] FRM_TC = C_CNT_WIDTH'(C_DISP_FRAMES - 1);
  localparam logic [C_CNT_WIDTH-1:0] BL_TC  = C_CNT_WIDTH'(C_BL_DELAY_CYCLES - 1);
  localparam logic [C_CNT_WIDTH-1:0] ONE    = C_CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   fs_q, fs_d;
  logic                   panel_pwr_q, panel_pwr_d;
  logic                   timing_en_q, timing_en_d;
  logic                   lcd_disp_q, lcd_disp_d;
  logic                   bl_en_q, bl_en_d;
  logic                   status_on_q, status_on_d;
  logic                   busy_q, busy_d;
  logic                   frame_edge;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + ONE;
    frame_edge = FRAME_START & ~fs_q;
    // the edge detector is held clear while EN is low so the first frame after EN counts
    fs_d       = timing_en_q ? FRAME_START : 1'b0;

    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (REQ_ON) state_d = S_PWR_UP;
      end
      S_PWR_UP:   if (cnt_q == PWR_TC) state_d = S_FWAIT_UP;
      S_FWAIT_UP: begin
        cnt_d = frame_edge ? cnt_q + ONE : cnt_q;
        if (frame_edge && cnt_q == FRM_TC) state_d = S_DISP_UP;
      end
      S_DISP_UP:  if (cnt_q == BL_TC) state_d = S_ON;
      S_ON: begin
        cnt_d = '0;
        if (!REQ_ON) state_d = S_BL_DN;
      end
      S_BL_DN:    if (cnt_q == BL_TC) state_d = S_FWAIT_DN;
      S_FWAIT_DN: begin
        cnt_d = frame_edge ? cnt_q + ONE : cnt_q;
        if (frame_edge && cnt_q == FRM_TC) state_d = S_PWR_DN;
      end
      S_PWR_DN:   if (cnt_q == PWR_TC) state_d = S_OFF;
      default:    state_d = S_OFF;
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (FORCE_OFF) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end

    // outputs are registered from the next state so they line up with state_q
    panel_pwr_d = (state_d != S_OFF);
    timing_en_d = state_d inside {S_FWAIT_UP, S_DISP_UP, S_ON, S_BL_DN, S_FWAIT_DN};
    lcd_disp_d  = state_d inside {S_DISP_UP, S_ON, S_BL_DN};
    bl_en_d     = (state_d == S_ON);
    status_on_d = (state_d == S_ON);
    busy_d      = (state_d != S_OFF) && (state_d != S_ON);
  end

  always_ff @(posedge PCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      fs_q        <= 1'b0;
      panel_pwr_q <= 1'b0;
      timing_en_q <= 1'b0;
      lcd_disp_q  <= 1'b0;
      bl_en_q     <= 1'b0;
      status_on_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fs_q        <= fs_d;
      panel_pwr_q <= panel_pwr_d;
      timing_en_q <= timing_en_d;
      lcd_disp_q  <= lcd_disp_d;
      bl_en_q     <= bl_en_d;
      status_on_q <= status_on_d;
      busy_q      <= busy_d;
    end
  end

  assign PANEL_PWR = panel_pwr_q;
  assign TIMING_EN = timing_en_q;
  assign LCD_DISP  = lcd_disp_q;
  assign BL_EN     = bl_en_q;
  assign STATUS_ON = status_on_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_gslcd_v1_0_power_seq.sv
// Bench for the LCD power sequencer: a rail-level reference model (how many rails are up,
// which way the sequence is moving) plus a timing-generator model driving FRAME_START.
module tb_gslcd_v1_0_power_seq;

  localparam int PWR = 4;
  localparam int FR  = 2;
  localparam int BL  = 3;

  logic PCLK = 1'b0;
  logic RESETN = 1'b1;
  logic REQ_ON = 1'b0;
  logic FORCE_OFF = 1'b0;
  logic FRAME_START = 1'b0;
  logic PANEL_PWR, TIMING_EN, LCD_DISP, BL_EN, STATUS_ON, BUSY;

  gslcd_v1_0_power_seq #(
    .C_CNT_WIDTH(20),
    .C_PWR_DELAY_CYCLES(PWR),
    .C_DISP_FRAMES(FR),
    .C_BL_DELAY_CYCLES(BL)
  ) dut (
    .PCLK(PCLK),
    .RESETN(RESETN),
    .REQ_ON(REQ_ON),
    .FORCE_OFF(FORCE_OFF),
    .FRAME_START(FRAME_START),
    .PANEL_PWR(PANEL_PWR),
    .TIMING_EN(TIMING_EN),
    .LCD_DISP(LCD_DISP),
    .BL_EN(BL_EN),
    .STATUS_ON(STATUS_ON),
    .BUSY(BUSY)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // model: m_level = number of rails up (0..4), m_dir = +1 rising, -1 falling, 0 settled
  int m_level = 0;
  int m_dir = 0;
  int m_prog = 0;
  bit m_fs_prev = 1'b0;
  int tg = 0;
  int fs_mode = 0;  // 0 periodic frames, 1 held high while EN, 2 random while EN

  function automatic logic [5:0] m_out();
    logic [5:0] v;
    v[5] = (m_level >= 1);
    v[4] = (m_level >= 2);
    v[3] = (m_level >= 3);
    v[2] = (m_level >= 4);
    v[1] = (m_level == 4);
    v[0] = (m_dir != 0);
    return v;
  endfunction

  function automatic logic [5:0] dut_vec();
    return {PANEL_PWR, TIMING_EN, LCD_DISP, BL_EN, STATUS_ON, BUSY};
  endfunction

  // dwell needed to leave level L is the same going up or down
  function automatic int need(int lvl);
    if (lvl == 1) return PWR;
    if (lvl == 2) return FR;
    return BL;
  endfunction

  task automatic model_reset();
    m_level = 0; m_dir = 0; m_prog = 0; m_fs_prev = 1'b0; tg = 0;
  endtask

  task automatic model_step();
    bit en_before;
    bit fedge;
    en_before = (m_level >= 2);
    fedge = FRAME_START && !m_fs_prev;
    if (FORCE_OFF) begin
      m_level = 0; m_dir = 0; m_prog = 0;
    end else if (m_dir == 0) begin
      if (m_level == 0 && REQ_ON) begin
        m_level = 1; m_dir = 1; m_prog = 0;
      end else if (m_level == 4 && !REQ_ON) begin
        m_level = 3; m_dir = -1; m_prog = 0;
      end
    end else begin
      if (m_level != 2 || fedge) m_prog++;
      if (m_prog == need(m_level)) begin
        m_level = m_level + m_dir;
        m_prog = 0;
        if (m_level == 0 || m_level == 4) m_dir = 0;
      end
    end
    m_fs_prev = en_before ? FRAME_START : 1'b0;
  endtask

  task automatic tick();
    bit en_was;
    en_was = (m_level >= 2);
    @(posedge PCLK);
    model_step();
    if (m_level >= 2) tg = en_was ? (tg + 1) % 20 : 0;
    else tg = 0;
    #1;
    case (fs_mode)
      0: FRAME_START = (m_level >= 2) && (tg < 5);
      1: FRAME_START = (m_level >= 2);
      default: FRAME_START = (m_level >= 2) && ($urandom_range(0, 3) == 0);
    endcase
    cyc++;
  endtask

  task automatic test_reset();
    #1 RESETN = 1'b0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    if (dut_vec() !== 6'b0) begin
      n_bad++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 6'b0);
    end
    n_cmp++;
    RESETN = 1'b1;
    tick();
    if (dut_vec() !== m_out()) begin
      n_bad++; $display("FAIL reset_idle got=%b exp=%b", dut_vec(), m_out());
    end
    n_cmp++;
  endtask

  task automatic test_power_up();
    int k = 0;
    int t_pwr = -1, t_en = -1, t_disp = -1, t_bl = -1, t_fs2 = -1;
    int rises = 0;
    bit prev_fs = 1'b0;
    REQ_ON = 1'b1;
    while (k < 200 && m_level != 4) begin
      tick(); k++;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL pu_seq k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
      if (FRAME_START && !prev_fs) begin rises++; if (rises == 2) t_fs2 = k; end
      prev_fs = FRAME_START;
      if (PANEL_PWR === 1'b1 && t_pwr < 0) t_pwr = k;
      if (TIMING_EN === 1'b1 && t_en < 0) t_en = k;
      if (LCD_DISP === 1'b1 && t_disp < 0) t_disp = k;
      if (BL_EN === 1'b1 && t_bl < 0) t_bl = k;
    end
    if (m_level != 4) begin
      n_cmp++; n_bad++; $display("FAIL pu_timeout k=%0d", k);
    end
    if (t_pwr != 1) begin n_bad++; $display("FAIL pu_pwr_time got=%0d exp=1", t_pwr); end
    n_cmp++;
    if (t_en != 1 + PWR) begin n_bad++; $display("FAIL pu_en_time got=%0d exp=%0d", t_en, 1 + PWR); end
    n_cmp++;
    if (t_disp != t_fs2 + 1) begin n_bad++; $display("FAIL pu_disp_time got=%0d exp=%0d", t_disp, t_fs2 + 1); end
    n_cmp++;
    if (t_bl != t_disp + BL) begin n_bad++; $display("FAIL pu_bl_time got=%0d exp=%0d", t_bl, t_disp + BL); end
    n_cmp++;
  endtask

  task automatic test_power_down();
    int k = 0;
    int t_bl = -1, t_disp = -1, t_en = -1, t_pwr = -1;
    REQ_ON = 1'b0;
    while (k < 300 && !(k > 0 && m_level == 0)) begin
      tick(); k++;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL pd_seq k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
      if (BL_EN === 1'b0 && t_bl < 0) t_bl = k;
      if (LCD_DISP === 1'b0 && t_disp < 0) t_disp = k;
      if (TIMING_EN === 1'b0 && t_en < 0) t_en = k;
      if (PANEL_PWR === 1'b0 && t_pwr < 0) t_pwr = k;
    end
    if (m_level != 0) begin
      n_cmp++; n_bad++; $display("FAIL pd_timeout k=%0d", k);
    end
    if (t_bl != 1) begin n_bad++; $display("FAIL pd_bl_time got=%0d exp=1", t_bl); end
    n_cmp++;
    if (t_disp != t_bl + BL) begin n_bad++; $display("FAIL pd_disp_time got=%0d exp=%0d", t_disp, t_bl + BL); end
    n_cmp++;
    if (t_pwr != t_en + PWR) begin n_bad++; $display("FAIL pd_pwr_time got=%0d exp=%0d", t_pwr, t_en + PWR); end
    n_cmp++;
  endtask

  task automatic test_glitch();
    int k = 0;
    int on_cycles = 0;
    bit seen_on = 1'b0;
    REQ_ON = 1'b1;
    tick();
    REQ_ON = 1'b0;
    while (k < 400 && !(seen_on && m_level == 0)) begin
      tick(); k++;
      if (m_level == 4) seen_on = 1'b1;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL gl_seq k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
      if (STATUS_ON === 1'b1) on_cycles++;
    end
    if (!(seen_on && m_level == 0)) begin
      n_cmp++; n_bad++; $display("FAIL gl_timeout k=%0d", k);
    end
    if (on_cycles != 1) begin n_bad++; $display("FAIL gl_on_cycles got=%0d exp=1", on_cycles); end
    n_cmp++;
  endtask

  task automatic test_force_off();
    int k = 0;
    REQ_ON = 1'b1;
    while (k < 100 && m_level != 2) begin
      tick(); k++;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL fo_pre k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
    end
    FORCE_OFF = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dut_vec() !== 6'b0) begin
        n_bad++; $display("FAIL fo_hold i=%0d got=%b exp=%b", i, dut_vec(), 6'b0);
      end
      n_cmp++;
    end
    FORCE_OFF = 1'b0;
    tick();
    if (PANEL_PWR !== 1'b1 || BUSY !== 1'b1) begin
      n_bad++; $display("FAIL fo_release pwr=%b busy=%b exp=1,1", PANEL_PWR, BUSY);
    end
    n_cmp++;
    REQ_ON = 1'b0;
    k = 0;
    while (k < 400 && m_level != 0) begin
      tick(); k++;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL fo_post k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    REQ_ON = 1'b1;
    while (k < 100 && m_level != 3) begin
      tick(); k++;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL rm_pre k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
    end
    #2 RESETN = 1'b0;
    #1;
    if (dut_vec() !== 6'b0) begin
      n_bad++; $display("FAIL rm_async got=%b exp=%b", dut_vec(), 6'b0);
    end
    n_cmp++;
    model_reset();
    FRAME_START = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 RESETN = 1'b1;
    tick();
    if (dut_vec() !== m_out() || PANEL_PWR !== 1'b1 || TIMING_EN !== 1'b0) begin
      n_bad++; $display("FAIL rm_restart got=%b exp=%b", dut_vec(), m_out());
    end
    n_cmp++;
    k = 0;
    while (k < 200 && m_level != 4) begin
      tick(); k++;
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL rm_post k=%0d got=%b exp=%b", k, dut_vec(), m_out());
      end
      n_cmp++;
    end
  endtask

  task automatic test_fs_held();
    int k = 0;
    REQ_ON = 1'b0;
    while (k < 300 && !(k > 0 && m_level == 0)) begin
      tick(); k++;
    end
    fs_mode = 1;
    REQ_ON = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL fh_seq i=%0d got=%b exp=%b", i, dut_vec(), m_out());
      end
      n_cmp++;
    end
    if (TIMING_EN !== 1'b1 || LCD_DISP !== 1'b0) begin
      n_bad++; $display("FAIL fh_stuck en=%b disp=%b exp=1,0", TIMING_EN, LCD_DISP);
    end
    n_cmp++;
    FORCE_OFF = 1'b1;
    REQ_ON = 1'b0;
    tick();
    FORCE_OFF = 1'b0;
    fs_mode = 0;
    tick();
    if (dut_vec() !== 6'b0) begin
      n_bad++; $display("FAIL fh_exit got=%b exp=%b", dut_vec(), 6'b0);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      fs_mode = (i < 2000) ? 0 : 2;
      if ($urandom_range(0, 29) == 0) REQ_ON = $urandom_range(0, 1) == 1;
      FORCE_OFF = ($urandom_range(0, 299) == 0);
      tick();
      if (dut_vec() !== m_out()) begin
        n_bad++; $display("FAIL rnd_seq i=%0d got=%b exp=%b", i, dut_vec(), m_out());
      end
      n_cmp++;
    end
    FORCE_OFF = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_glitch();
    test_force_off();
    test_reset_mid();
    test_fs_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
